wide_add_seq: RTL and testbench



---
 rtl/wide_add_seq_if.sv | 14 +
 rtl/wide_add_seq.sv | 68 ++++++
 tb/tb_wide_add_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if: start/operand request and result bundle for the multi-word add/sub sequencer.
interface wide_add_seq_if #(parameter int N = 32, parameter int WORDS = 4);
  logic start;
  logic sub;
  logic [N*WORDS-1:0] a;
  logic [N*WORDS-1:0] b;
  logic busy;
  logic done;
  logic [N*WORDS-1:0] sum;
  logic cout;
  logic ovf;
  modport master(output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave(input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/wide_add_seq.sv
// wide_add_seq: (N*WORDS)-bit add/subtract computed one N-bit word per cycle on a single ripple adder.
module wide_add_seq #(
  parameter int N = 32,
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst_n,
  wide_add_seq_if.slave bus
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [WORDS-1:0][N-1:0] a_q, b_q, sum_q;
  logic [IW-1:0] idx;
  logic sub_q, c_q, cout_q, ovf_q, done_q;
  logic [N-1:0] op_a, op_b, s;
  logic co, last;
  // The only adder; subtraction is A + ~B + 1 with the +1 seeded into c_q at start.
  assign op_a = a_q[idx];
  assign op_b = b_q[idx] ^ {N{sub_q}};
  assign {co, s} = {1'b0, op_a} + {1'b0, op_b} + {{N{1'b0}}, c_q};
  assign last = idx == IW'(WORDS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = bus.start ? RUN : IDLE;
    else state_nx = last ? IDLE : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      sub_q <= 1'b0;
      c_q <= 1'b0;
      idx <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a_q <= bus.a;
          b_q <= bus.b;
          sub_q <= bus.sub;
          c_q <= bus.sub;
          idx <= '0;
        end
      end else begin
        sum_q[idx] <= s;
        c_q <= co;
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          cout_q <= co;
          ovf_q <= (op_a[N-1] ~^ op_b[N-1]) & (s[N-1] ^ op_a[N-1]);
          done_q <= 1'b1;
        end
      end
    end
  assign bus.busy = state == RUN;
  assign bus.done = done_q;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed vectors against literal expectations plus a per-cycle arithmetic reference model.
module tb_wide_add_seq;
  localparam int N = 32;
  localparam int WORDS = 4;
  localparam int W = N * WORDS;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;
  wide_add_seq_if #(.N(N), .WORDS(WORDS)) bus ();
  wide_add_seq #(.N(N), .WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Whole-width arithmetic: returns {ovf, cout, sum}.
  function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] full;
    logic ov;
    full = {1'b0, a} + {1'b0, sub ? ~b : b} + {{W{1'b0}}, sub};
    ov = ((a[W-1] != b[W-1]) == sub) && (full[W-1] != a[W-1]);
    return {ov, full};
  endfunction
  logic m_busy, m_done, m_cout, m_ovf, m_sub;
  logic [W-1:0] m_sum, m_a, m_b;
  int m_rem;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sum <= '0;
      m_cout <= 1'b0;
      m_ovf <= 1'b0;
      m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && bus.start) begin
        m_busy <= 1'b1;
        m_rem <= WORDS;
        m_a <= bus.a;
        m_b <= bus.b;
        m_sub <= bus.sub;
      end else if (m_busy) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_ovf, m_cout, m_sum} <= calc(m_a, m_b, m_sub);
        end
      end
    end
  always @(negedge clk)
    if (run_cmp) begin
      chk("model busy", W'(bus.busy), W'(m_busy));
      chk("model done", W'(bus.done), W'(m_done));
      chk("model cout", W'(bus.cout), W'(m_cout));
      chk("model ovf", W'(bus.ovf), W'(m_ovf));
      if (!m_busy) chk("model sum", bus.sum, m_sum);
    end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.sub = sub;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(input string name, output int lat, output int bc);
    lat = 0;
    bc = 0;
    forever begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) break;
      if (lat > 20) begin
        chk({name, " timeout"}, W'(0), W'(1));
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask
  task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    int lat, bc;
    @(negedge clk);
    issue(a, b, sub);
    wait_done(name, lat, bc);
    chk({name, " latency"}, W'(lat), W'(4));
    chk({name, " busy cycles"}, W'(bc), W'(4));
    chk({name, " sum"}, bus.sum, es);
    chk({name, " cout"}, W'(bus.cout), W'(ec));
    chk({name, " ovf"}, W'(bus.ovf), W'(eo));
  endtask
  initial begin
    logic [W-1:0] ones, msb;
    int lat, bc, dc;
    ones = '1;
    msb = '0;
    msb[W-1] = 1'b1;
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1;
    chk("reset busy", W'(bus.busy), W'(0));
    chk("reset done", W'(bus.done), W'(0));
    chk("reset sum", bus.sum, W'(0));
    chk("reset cout/ovf", W'({bus.cout, bus.ovf}), W'(0));
    #22 rst_n = 1'b1;
    run_cmp = 1'b1;
    op_check("full carry", ones, W'(1), 1'b0, W'(0), 1'b1, 1'b0);
    op_check("word ripple", W'(96'hFFFFFFFF_FFFFFFFF_FFFFFFFF), W'(1), 1'b0, W'(1) << 96, 1'b0, 1'b0);
    op_check("borrow", W'(0), W'(1), 1'b1, ones, 1'b0, 1'b0);
    op_check("5-3", W'(5), W'(3), 1'b1, W'(2), 1'b1, 1'b0);
    op_check("pos ovf", ~msb, W'(1), 1'b0, msb, 1'b0, 1'b1);
    op_check("neg ovf", msb, W'(1), 1'b1, ~msb, 1'b1, 1'b1);
    // start held through RUN while operands wander; only the first capture counts
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(2);
    bus.b = W'(3);
    bus.sub = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      bus.a = {$urandom, $urandom, $urandom, $urandom};
      bus.b = {$urandom, $urandom, $urandom, $urandom};
      bus.sub = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    chk("held start done count", W'(dc), W'(1));
    chk("held start sum", bus.sum, W'(5));
    op_check("first of pair", W'(10), W'(20), 1'b0, W'(30), 1'b0, 1'b0);
    issue(W'(100), W'(1), 1'b1);
    wait_done("second of pair", lat, bc);
    chk("done to done gap", W'(lat + 1), W'(5));
    chk("second of pair sum", bus.sum, W'(99));
    chk("second of pair cout", W'(bus.cout), W'(1));
    // abort after the 2nd RUN edge
    @(negedge clk);
    issue(ones, ones, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", W'(bus.busy), W'(0));
    chk("abort done", W'(bus.done), W'(0));
    chk("abort sum", bus.sum, W'(0));
    chk("abort cout/ovf", W'({bus.cout, bus.ovf}), W'(0));
    dc = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    chk("abort no done", W'(dc), W'(0));
    op_check("after reset", W'(2), W'(3), 1'b0, W'(5), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
